// File: rtl/detect_pkg.sv
// detect_pkg: shared definitions for the detect event counter.
//   state_t    - re-arm FSM state encoding (IDLE=0, HIGH=1, GAP=2)
//   gap_cnt_w  - width of the gap down-counter for a given GAP_CYC
package detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  // The gap counter holds at most GAP_CYC-1; keep at least one bit.
  function automatic int unsigned gap_cnt_w(input int unsigned gap_cyc);
    return (gap_cyc <= 2) ? 1 : $clog2(gap_cyc);
  endfunction

endpackage

// File: rtl/detect_rearm_fsm.sv
// detect_rearm_fsm: registers the upstream detect level and tracks whether the
// counter is armed for a new event.
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   i_detect   in   detect level from upstream FSM
//   o_arm_hit  out  one-cycle pulse: registered detect seen high while armed
module detect_rearm_fsm
  import detect_pkg::*;
#(
  parameter int unsigned GAP_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_detect,
  output logic o_arm_hit
);

  localparam int unsigned     GW       = gap_cnt_w(GAP_CYC);
  localparam logic [GW-1:0]   GAP_LOAD = (GAP_CYC > 1) ? GW'(GAP_CYC - 1) : '0;
  localparam logic [GW-1:0]   GAP_ONE  = GW'(1);

  logic          r_d_q;
  state_t        r_state;
  logic [GW-1:0] r_gap_cnt;

  // The low cycle that leaves HIGH is the first of the GAP_CYC required, so
  // gap_cnt holds the lows still needed; GAP exits on the last of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_q     <= 1'b0;
      r_state   <= IDLE;
      r_gap_cnt <= '0;
    end else begin
      r_d_q <= i_detect;
      case (r_state)
        IDLE: begin
          if (r_d_q) r_state <= HIGH;
        end
        HIGH: begin
          if (!r_d_q) begin
            if (GAP_CYC <= 1) begin
              r_state <= IDLE;
            end else begin
              r_state   <= GAP;
              r_gap_cnt <= GAP_LOAD;
            end
          end
        end
        GAP: begin
          if (r_d_q) begin
            r_state <= HIGH;
          end else if (r_gap_cnt <= GAP_ONE) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_arm_hit = (r_state == IDLE) && r_d_q;
  end

endmodule

// File: rtl/detect_event_counter.sv
// detect_event_counter: counts qualified detect events in a saturating counter
// with sticky alarm and saturation flags.
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   detect_i  in   detect level from upstream Moore FSM
//   enable_i  in   1 = events counted
//   clear_i   in   synchronous clear of count/alarm/sat/event
//   event_o   out  one-cycle pulse per qualified event
//   count_o   out  saturating event count
//   alarm_o   out  sticky, count reached ALARM_TH
//   sat_o     out  sticky, an event was lost at saturation
module detect_event_counter
  import detect_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned GAP_CYC  = 2,
  parameter int unsigned ALARM_TH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             detect_i,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic             event_o,
  output logic [CNT_W-1:0] count_o,
  output logic             alarm_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TH  = CNT_W'(ALARM_TH);

  logic             w_arm_hit;
  logic             w_qual;
  logic             w_at_max;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             r_event;
  logic [CNT_W-1:0] r_count;
  logic             r_alarm;
  logic             r_sat;

  detect_rearm_fsm #(
    .GAP_CYC(GAP_CYC)
  ) u_rearm (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_detect (detect_i),
    .o_arm_hit(w_arm_hit)
  );

  // Clear drops a coincident event rather than counting it.
  always_comb begin
    w_qual    = w_arm_hit & enable_i & ~clear_i;
    w_at_max  = (r_count == CNT_MAX);
    w_cnt_nxt = (w_qual && !w_at_max) ? r_count + CNT_ONE : r_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_event <= 1'b0;
      r_count <= '0;
      r_alarm <= 1'b0;
      r_sat   <= 1'b0;
    end else if (clear_i) begin
      r_event <= 1'b0;
      r_count <= '0;
      r_alarm <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_event <= w_qual;
      r_count <= w_cnt_nxt;
      if (w_qual && w_at_max) r_sat <= 1'b1;
      if (w_cnt_nxt >= CNT_TH) r_alarm <= 1'b1;
    end
  end

  assign event_o = r_event;
  assign count_o = r_count;
  assign alarm_o = r_alarm;
  assign sat_o   = r_sat;

endmodule

// File: tb/tb_detect_event_counter.sv
// tb_detect_event_counter: scenario tasks drive detect/enable/clear; expected
// counts for each qualified event are queued when a pulse is driven and
// popped by a monitor whenever the default instance pulses event_o.
// A second instance with CNT_W=3 shares the stimulus for saturation checks.
module tb_detect_event_counter;

  logic       clk;
  logic       rst_n;
  logic       detect_i;
  logic       enable_i;
  logic       clear_i;
  logic       event_o;
  logic [7:0] count_o;
  logic       alarm_o;
  logic       sat_o;
  logic       s_event;
  logic [2:0] s_count;
  logic       s_alarm;
  logic       s_sat;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  int exp_q[$];
  int exp_v;

  detect_event_counter #(
    .CNT_W   (8),
    .GAP_CYC (2),
    .ALARM_TH(5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .detect_i(detect_i),
    .enable_i(enable_i),
    .clear_i (clear_i),
    .event_o (event_o),
    .count_o (count_o),
    .alarm_o (alarm_o),
    .sat_o   (sat_o)
  );

  detect_event_counter #(
    .CNT_W   (3),
    .GAP_CYC (2),
    .ALARM_TH(5)
  ) dut_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .detect_i(detect_i),
    .enable_i(enable_i),
    .clear_i (clear_i),
    .event_o (s_event),
    .count_o (s_count),
    .alarm_o (s_alarm),
    .sat_o   (s_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every event pulse must match the next queued count.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && event_o === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: event_o=1 count_o=%0d, no event queued", count_o);
      end else begin
        exp_v = exp_q.pop_front();
        if (count_o !== 8'(exp_v)) begin
          bad++;
          $display("FAIL event_count: count_o=%0d expected %0d", count_o, exp_v);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_pulse(input int hi, input int lo);
    exp_cnt++;
    exp_q.push_back(exp_cnt);
    detect_i = 1'b1;
    cyc(hi);
    detect_i = 1'b0;
    cyc(lo);
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    cyc(1);
    clear_i = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (count_o !== 8'd0 || event_o !== 1'b0 || alarm_o !== 1'b0 || sat_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: cnt=%0d ev=%b al=%b sat=%b expected all 0", count_o, event_o, alarm_o, sat_o);
    end
    total++;
    if (s_count !== 3'd0 || s_sat !== 1'b0) begin
      bad++;
      $display("FAIL reset_sat_inst: cnt=%0d sat=%b expected 0 0", s_count, s_sat);
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    total++;
    if (count_o !== 8'd0) begin
      bad++;
      $display("FAIL reset_release: count_o=%0d expected 0", count_o);
    end
  endtask

  task automatic test_single();
    exp_cnt++;
    exp_q.push_back(exp_cnt);
    detect_i = 1'b1;
    cyc(1);
    total++;
    if (event_o !== 1'b0 || count_o !== 8'd0) begin
      bad++;
      $display("FAIL single_edge1: ev=%b cnt=%0d expected 0 0", event_o, count_o);
    end
    cyc(1);
    total++;
    if (event_o !== 1'b1 || count_o !== 8'd1) begin
      bad++;
      $display("FAIL single_edge2: ev=%b cnt=%0d expected 1 1", event_o, count_o);
    end
    cyc(1);
    total++;
    if (event_o !== 1'b0 || count_o !== 8'd1) begin
      bad++;
      $display("FAIL single_held: ev=%b cnt=%0d expected 0 1", event_o, count_o);
    end
    detect_i = 1'b0;
    cyc(4);
    total++;
    if (count_o !== 8'd1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_final: cnt=%0d pending=%0d expected 1 0", count_o, exp_q.size());
    end
  endtask

  task automatic test_bounce();
    do_clear();
    total++;
    if (count_o !== 8'd0) begin
      bad++;
      $display("FAIL bounce_clear: count_o=%0d expected 0", count_o);
    end
    exp_cnt++;
    exp_q.push_back(exp_cnt);
    detect_i = 1'b1; cyc(2);
    detect_i = 1'b0; cyc(1);
    detect_i = 1'b1; cyc(2);
    detect_i = 1'b0; cyc(2);
    total++;
    if (count_o !== 8'd1) begin
      bad++;
      $display("FAIL bounce_absorbed: count_o=%0d expected 1", count_o);
    end
    exp_cnt++;
    exp_q.push_back(exp_cnt);
    detect_i = 1'b1; cyc(2);
    detect_i = 1'b0; cyc(4);
    total++;
    if (count_o !== 8'd2 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bounce_rearm: cnt=%0d pending=%0d expected 2 0", count_o, exp_q.size());
    end
  endtask

  task automatic test_alarm();
    do_clear();
    for (int i = 1; i <= 5; i++) begin
      exp_cnt++;
      exp_q.push_back(exp_cnt);
      detect_i = 1'b1; cyc(1);
      detect_i = 1'b0; cyc(1);
      total++;
      if (count_o !== 8'(i) || alarm_o !== (i >= 5)) begin
        bad++;
        $display("FAIL alarm_step%0d: cnt=%0d al=%b expected %0d %b", i, count_o, alarm_o, i, (i >= 5));
      end
      cyc(3);
    end
    do_clear();
    total++;
    if (count_o !== 8'd0 || alarm_o !== 1'b0) begin
      bad++;
      $display("FAIL alarm_clear: cnt=%0d al=%b expected 0 0", count_o, alarm_o);
    end
    do_pulse(1, 4);
    total++;
    if (count_o !== 8'd1 || alarm_o !== 1'b0) begin
      bad++;
      $display("FAIL alarm_after_clear: cnt=%0d al=%b expected 1 0", count_o, alarm_o);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    for (int i = 1; i <= 9; i++) begin
      do_pulse(1, 4);
      if (i == 7) begin
        total++;
        if (s_count !== 3'd7 || s_sat !== 1'b0) begin
          bad++;
          $display("FAIL sat_at_max: cnt=%0d sat=%b expected 7 0", s_count, s_sat);
        end
      end
      if (i == 8) begin
        total++;
        if (s_count !== 3'd7 || s_sat !== 1'b1) begin
          bad++;
          $display("FAIL sat_first_loss: cnt=%0d sat=%b expected 7 1", s_count, s_sat);
        end
      end
    end
    total++;
    if (s_count !== 3'd7 || s_sat !== 1'b1 || s_alarm !== 1'b1) begin
      bad++;
      $display("FAIL sat_final: cnt=%0d sat=%b al=%b expected 7 1 1", s_count, s_sat, s_alarm);
    end
    total++;
    if (count_o !== 8'd9 || sat_o !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL sat_wide_inst: cnt=%0d sat=%b pending=%0d expected 9 0 0", count_o, sat_o, exp_q.size());
    end
  endtask

  task automatic test_clear_enable();
    do_clear();
    detect_i = 1'b1;
    cyc(1);
    clear_i = 1'b1;
    cyc(1);
    total++;
    if (event_o !== 1'b0 || count_o !== 8'd0) begin
      bad++;
      $display("FAIL clear_collision: ev=%b cnt=%0d expected 0 0", event_o, count_o);
    end
    clear_i = 1'b0;
    cyc(3);
    total++;
    if (count_o !== 8'd0) begin
      bad++;
      $display("FAIL clear_no_recount: count_o=%0d expected 0", count_o);
    end
    detect_i = 1'b0;
    cyc(4);
    enable_i = 1'b0;
    detect_i = 1'b1; cyc(1);
    detect_i = 1'b0; cyc(4);
    total++;
    if (count_o !== 8'd0) begin
      bad++;
      $display("FAIL disabled_pulse: count_o=%0d expected 0", count_o);
    end
    detect_i = 1'b1;
    cyc(2);
    enable_i = 1'b1;
    cyc(3);
    total++;
    if (count_o !== 8'd0) begin
      bad++;
      $display("FAIL no_replay: count_o=%0d expected 0", count_o);
    end
    detect_i = 1'b0;
    cyc(4);
    do_pulse(1, 4);
    total++;
    if (count_o !== 8'd1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL enable_resume: cnt=%0d pending=%0d expected 1 0", count_o, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    detect_i = 1'b1;
    cyc(1);
    rst_n = 1'b0;
    #2;
    total++;
    if (count_o !== 8'd0 || event_o !== 1'b0 || alarm_o !== 1'b0 || sat_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: cnt=%0d ev=%b al=%b sat=%b expected all 0", count_o, event_o, alarm_o, sat_o);
    end
    total++;
    if (s_count !== 3'd0 || s_sat !== 1'b0 || s_alarm !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_sat: cnt=%0d sat=%b al=%b expected 0 0 0", s_count, s_sat, s_alarm);
    end
    exp_cnt = 0;
    exp_q.delete();
    cyc(2);
    rst_n = 1'b1;
    exp_cnt++;
    exp_q.push_back(exp_cnt);
    cyc(1);
    total++;
    if (count_o !== 8'd0 || event_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_rel_edge1: cnt=%0d ev=%b expected 0 0", count_o, event_o);
    end
    cyc(1);
    total++;
    if (count_o !== 8'd1 || event_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_rel_edge2: cnt=%0d ev=%b expected 1 1", count_o, event_o);
    end
    detect_i = 1'b0;
    cyc(4);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL reset_pending: pending=%0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    detect_i = 1'b0;
    enable_i = 1'b1;
    clear_i  = 1'b0;
    test_reset();
    test_single();
    test_bounce();
    test_alarm();
    test_saturation();
    test_clear_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
